// File: rtl/packet_injector.sv
// Per-node traffic source: walks the local packet table in order and injects
// head/body/tail flits into the router's local port under per-VC credit control.
module packet_injector #(
  parameter  int NODE_ID        = 0,
  parameter  int NUM_OF_ROUTERS = 16,
  parameter  int NUM_OF_VCS     = 2,
  parameter  int VCS_SIZE       = 4,
  parameter  int MAX_PACKETS    = 64,
  parameter  int FLIT_CNT_W     = 8,
  localparam int NW             = $clog2(NUM_OF_ROUTERS),
  localparam int VW             = (NUM_OF_VCS > 1) ? $clog2(NUM_OF_VCS) : 1,
  localparam int PW             = $clog2(MAX_PACKETS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PW:0]           num_of_packets,
  output logic [PW-1:0]         pkt_idx,
  input  logic [NW-1:0]         pkt_dest,
  input  logic [VW-1:0]         pkt_vc,
  input  logic [FLIT_CNT_W-1:0] pkt_num_of_flits,
  input  logic                  credit_valid,
  input  logic [VW-1:0]         credit_vc,
  output logic                  flit_valid,
  output logic [1:0]            flit_type,
  output logic [VW-1:0]         flit_vc,
  output logic [NW-1:0]         flit_dest,
  output logic [NW-1:0]         flit_src,
  output logic [PW-1:0]         flit_pkt_id,
  output logic [FLIT_CNT_W-1:0] flit_seq,
  output logic                  done
);

  localparam int CW = $clog2(VCS_SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [PW:0]             total_reg, total_next;
  logic [PW-1:0]           idx_reg, idx_next;
  logic [NW-1:0]           cur_dest_reg, cur_dest_next;
  logic [VW-1:0]           cur_vc_reg, cur_vc_next;
  logic [FLIT_CNT_W-1:0]   cur_flits_reg, cur_flits_next;
  logic [FLIT_CNT_W-1:0]   seq_reg, seq_next;

  logic                    fire;
  logic [1:0]              type_next;
  logic                    last_pkt;
  logic                    last_flit;
  logic                    credit_ok;

  logic [CW-1:0]           credits [NUM_OF_VCS];
  logic [NUM_OF_VCS-1:0]   credit_drop;

  assign pkt_idx   = idx_reg;
  assign last_pkt  = ((PW+1)'(idx_reg) + (PW+1)'(1)) == total_reg;
  assign last_flit = seq_reg == (cur_flits_reg - FLIT_CNT_W'(1));
  assign credit_ok = credits[cur_vc_reg] != '0;

  // One counter per VC; a flit taken and a credit returned in the same cycle cancel out.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_OF_VCS; gi++) begin : g_credit
      logic          take;
      logic          give;
      logic [CW-1:0] cnt_reg;

      assign take = fire && (cur_vc_reg == VW'(gi));
      assign give = credit_valid && (credit_vc == VW'(gi));
      assign credit_drop[gi] = give && !take && (cnt_reg == CW'(VCS_SIZE));
      assign credits[gi] = cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= CW'(VCS_SIZE);
        end else if (take && !give) begin
          cnt_reg <= cnt_reg - CW'(1);
        end else if (give && !take && !credit_drop[gi]) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  endgenerate

  // A returned credit with nowhere to go means the router and this node disagree.
  credit_overflow_chk : assert property (@(posedge clk) disable iff (rst) credit_drop == '0)
    else $error("packet_injector: credit returned on a full VC was dropped");

  always_comb begin
    state_next     = state_reg;
    total_next     = total_reg;
    idx_next       = idx_reg;
    cur_dest_next  = cur_dest_reg;
    cur_vc_next    = cur_vc_reg;
    cur_flits_next = cur_flits_reg;
    seq_next       = seq_reg;
    fire           = 1'b0;
    type_next      = 2'b00;

    case (state_reg)
      IDLE: begin
        if (start) begin
          total_next = num_of_packets;
          idx_next   = '0;
          state_next = (num_of_packets == '0) ? DONE : LOAD;
        end
      end

      LOAD: begin
        cur_dest_next  = pkt_dest;
        cur_vc_next    = pkt_vc;
        cur_flits_next = pkt_num_of_flits;
        seq_next       = '0;
        if (pkt_num_of_flits == '0) begin
          idx_next   = idx_reg + PW'(1);
          state_next = last_pkt ? DONE : LOAD;
        end else begin
          state_next = SEND;
        end
      end

      SEND: begin
        if (credit_ok) begin
          fire     = 1'b1;
          seq_next = seq_reg + FLIT_CNT_W'(1);
          if (cur_flits_reg == FLIT_CNT_W'(1)) begin
            type_next = 2'b11;
          end else if (seq_reg == '0) begin
            type_next = 2'b01;
          end else if (last_flit) begin
            type_next = 2'b10;
          end else begin
            type_next = 2'b00;
          end
          if (last_flit) begin
            idx_next   = idx_reg + PW'(1);
            state_next = last_pkt ? DONE : LOAD;
          end
        end
      end

      DONE: begin
        state_next = DONE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      total_reg     <= '0;
      idx_reg       <= '0;
      cur_dest_reg  <= '0;
      cur_vc_reg    <= '0;
      cur_flits_reg <= '0;
      seq_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      total_reg     <= total_next;
      idx_reg       <= idx_next;
      cur_dest_reg  <= cur_dest_next;
      cur_vc_reg    <= cur_vc_next;
      cur_flits_reg <= cur_flits_next;
      seq_reg       <= seq_next;
    end
  end

  // Flit fields only update on a sent flit so they hold through stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_valid  <= 1'b0;
      flit_type   <= 2'b00;
      flit_vc     <= '0;
      flit_dest   <= '0;
      flit_src    <= '0;
      flit_pkt_id <= '0;
      flit_seq    <= '0;
      done        <= 1'b0;
    end else begin
      flit_valid <= fire;
      done       <= (state_reg == DONE);
      if (fire) begin
        flit_type   <= type_next;
        flit_vc     <= cur_vc_reg;
        flit_dest   <= cur_dest_reg;
        flit_src    <= NW'(NODE_ID);
        flit_pkt_id <= idx_reg;
        flit_seq    <= seq_reg;
      end
    end
  end

endmodule

// File: tb/tb_packet_injector.sv
// Directed scoreboard bench for packet_injector: expected flits are queued
// by the stimulus and popped by an independent monitor.
module tb_packet_injector;

  localparam int NODE_ID = 3;
  localparam int NR      = 16;
  localparam int NV      = 2;
  localparam int VS      = 4;
  localparam int MP      = 64;
  localparam int FW      = 8;
  localparam int NW      = 4;
  localparam int VW      = 1;
  localparam int PW      = 6;

  typedef struct packed {
    logic [1:0]    ftype;
    logic [VW-1:0] vc;
    logic [NW-1:0] dest;
    logic [NW-1:0] src;
    logic [PW-1:0] pid;
    logic [FW-1:0] seq;
  } flit_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW:0]   num_of_packets = '0;
  logic [PW-1:0] pkt_idx;
  logic [NW-1:0] pkt_dest;
  logic [VW-1:0] pkt_vc;
  logic [FW-1:0] pkt_num_of_flits;
  logic          credit_valid = 1'b0;
  logic [VW-1:0] credit_vc = '0;
  logic          flit_valid;
  logic [1:0]    flit_type;
  logic [VW-1:0] flit_vc;
  logic [NW-1:0] flit_dest;
  logic [NW-1:0] flit_src;
  logic [PW-1:0] flit_pkt_id;
  logic [FW-1:0] flit_seq;
  logic          done;

  logic [NW-1:0] tbl_dest  [MP];
  logic [VW-1:0] tbl_vc    [MP];
  logic [FW-1:0] tbl_flits [MP];

  assign pkt_dest         = tbl_dest[pkt_idx];
  assign pkt_vc           = tbl_vc[pkt_idx];
  assign pkt_num_of_flits = tbl_flits[pkt_idx];

  packet_injector #(
    .NODE_ID(NODE_ID), .NUM_OF_ROUTERS(NR), .NUM_OF_VCS(NV),
    .VCS_SIZE(VS), .MAX_PACKETS(MP), .FLIT_CNT_W(FW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_of_packets(num_of_packets),
    .pkt_idx(pkt_idx), .pkt_dest(pkt_dest), .pkt_vc(pkt_vc),
    .pkt_num_of_flits(pkt_num_of_flits), .credit_valid(credit_valid),
    .credit_vc(credit_vc), .flit_valid(flit_valid), .flit_type(flit_type),
    .flit_vc(flit_vc), .flit_dest(flit_dest), .flit_src(flit_src),
    .flit_pkt_id(flit_pkt_id), .flit_seq(flit_seq), .done(done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  flit_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic exp_flit(input logic [1:0] t, input int vc, input int dest,
                          input int pid, input int seq);
    flit_t f;
    f.ftype = t;
    f.vc    = VW'(vc);
    f.dest  = NW'(dest);
    f.src   = NW'(NODE_ID);
    f.pid   = PW'(pid);
    f.seq   = FW'(seq);
    exp_q.push_back(f);
  endtask

  task automatic set_pkt(input int i, input int dest, input int vc, input int n);
    tbl_dest[i]  = NW'(dest);
    tbl_vc[i]    = VW'(vc);
    tbl_flits[i] = FW'(n);
  endtask

  task automatic pulse_start(input int n);
    num_of_packets = (PW+1)'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic give_credit(input int vc);
    credit_valid = 1'b1;
    credit_vc    = VW'(vc);
    step();
    credit_valid = 1'b0;
  endtask

  // Monitor: every presented flit must match the head of the expected queue.
  initial begin
    flit_t got;
    flit_t want;
    forever begin
      @(negedge clk);
      if (flit_valid) begin
        got = '{flit_type, flit_vc, flit_dest, flit_src, flit_pkt_id, flit_seq};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit actual type=%b vc=%0d dest=%0d pid=%0d seq=%0d required none",
                   got.ftype, got.vc, got.dest, got.pid, got.seq);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL flit actual type=%b vc=%0d dest=%0d src=%0d pid=%0d seq=%0d required type=%b vc=%0d dest=%0d src=%0d pid=%0d seq=%0d",
                     got.ftype, got.vc, got.dest, got.src, got.pid, got.seq,
                     want.ftype, want.vc, want.dest, want.src, want.pid, want.seq);
          end else begin
            $display("flit type=%b vc=%0d dest=%0d src=%0d pid=%0d seq=%0d",
                     got.ftype, got.vc, got.dest, got.src, got.pid, got.seq);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MP; i++) set_pkt(i, 0, 0, 0);

    // Reset state
    step();
    chk("rst_flit_valid", 32'(flit_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pkt_idx", 32'(pkt_idx), 0);
    chk("rst_flit_fields", 32'({flit_type, flit_vc, flit_dest, flit_src, flit_pkt_id, flit_seq}), 0);
    rst = 1'b0;
    step();

    // Single-flit packet
    set_pkt(0, 5, 1, 1);
    exp_flit(2'b11, 1, 5, 0, 0);
    pulse_start(1);
    step();
    chk("t1_no_flit_in_load", 32'(flit_valid), 0);
    step();
    chk("t1_flit_valid", 32'(flit_valid), 1);
    chk("t1_done_early", 32'(done), 0);
    step();
    chk("t1_done", 32'(done), 1);

    // Credit stall and resume
    do_reset();
    set_pkt(0, 9, 0, 6);
    exp_flit(2'b01, 0, 9, 0, 0);
    exp_flit(2'b00, 0, 9, 0, 1);
    exp_flit(2'b00, 0, 9, 0, 2);
    exp_flit(2'b00, 0, 9, 0, 3);
    exp_flit(2'b00, 0, 9, 0, 4);
    exp_flit(2'b10, 0, 9, 0, 5);
    pulse_start(1);
    step(); step(); step(); step(); step();
    chk("t2_seq3_valid", 32'(flit_valid), 1);
    step();
    chk("t2_stall_a", 32'(flit_valid), 0);
    step();
    chk("t2_stall_b", 32'(flit_valid), 0);
    chk("t2_seq_held", 32'(flit_seq), 3);
    give_credit(0);
    chk("t2_credit_not_same_cycle", 32'(flit_valid), 0);
    step();
    chk("t2_seq4_valid", 32'(flit_valid), 1);
    give_credit(0);
    chk("t2_stall_c", 32'(flit_valid), 0);
    step();
    chk("t2_seq5_valid", 32'(flit_valid), 1);
    chk("t2_done_early", 32'(done), 0);
    step();
    chk("t2_done", 32'(done), 1);

    // Simultaneous consume and return holds the counter at 1
    do_reset();
    set_pkt(0, 1, 0, 3);
    set_pkt(1, 6, 0, 5);
    set_pkt(2, 8, 0, 3);
    exp_flit(2'b01, 0, 1, 0, 0);
    exp_flit(2'b00, 0, 1, 0, 1);
    exp_flit(2'b10, 0, 1, 0, 2);
    for (int s = 0; s < 5; s++) exp_flit((s == 0) ? 2'b01 : ((s == 4) ? 2'b10 : 2'b00), 0, 6, 1, s);
    exp_flit(2'b01, 0, 8, 2, 0);
    exp_flit(2'b00, 0, 8, 2, 1);
    exp_flit(2'b10, 0, 8, 2, 2);
    pulse_start(3);
    step(); step(); step(); step(); step();
    chk("t3_bubble", 32'(flit_valid), 0);
    credit_valid = 1'b1;
    credit_vc    = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step();
      chk($sformatf("t3_every_cycle_%0d", s), 32'(flit_valid), 1);
    end
    credit_valid = 1'b0;
    step();
    chk("t3_load_bubble", 32'(flit_valid), 0);
    step();
    chk("t3_last_credit_used", 32'(flit_valid), 1);
    step();
    chk("t3_counter_was_one", 32'(flit_valid), 0);
    give_credit(0);
    step();
    chk("t3_p2_seq1", 32'(flit_valid), 1);
    give_credit(0);
    step();
    chk("t3_p2_tail", 32'(flit_valid), 1);
    step();
    chk("t3_done", 32'(done), 1);

    // Multi-packet mixed VCs with a zero-flit entry
    do_reset();
    set_pkt(0, 2, 0, 3);
    set_pkt(1, 7, 1, 2);
    set_pkt(2, 4, 0, 0);
    exp_flit(2'b01, 0, 2, 0, 0);
    exp_flit(2'b00, 0, 2, 0, 1);
    exp_flit(2'b10, 0, 2, 0, 2);
    exp_flit(2'b01, 1, 7, 1, 0);
    exp_flit(2'b10, 1, 7, 1, 1);
    pulse_start(3);
    step(); step(); step(); step();
    chk("t4_pkt0_tail", 32'(flit_valid), 1);
    step();
    chk("t4_bubble", 32'(flit_valid), 0);
    step(); step();
    chk("t4_pkt1_tail", 32'(flit_valid), 1);
    step();
    chk("t4_skip_no_flit", 32'(flit_valid), 0);
    chk("t4_done_early", 32'(done), 0);
    chk("t4_idx_after_skip", 32'(pkt_idx), 3);
    step();
    chk("t4_done", 32'(done), 1);

    // Empty list, then start ignored in DONE
    do_reset();
    pulse_start(0);
    chk("t5_done_early", 32'(done), 0);
    step();
    chk("t5_done", 32'(done), 1);
    set_pkt(0, 3, 0, 2);
    pulse_start(1);
    step(); step(); step();
    chk("t5_start_ignored", 32'(flit_valid), 0);
    chk("t5_done_sticky", 32'(done), 1);

    // Reset mid-packet, then replay from packet 0
    do_reset();
    set_pkt(0, 5, 1, 4);
    exp_flit(2'b01, 1, 5, 0, 0);
    exp_flit(2'b00, 1, 5, 0, 1);
    pulse_start(1);
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t6_async_flit_valid", 32'(flit_valid), 0);
    chk("t6_async_fields", 32'({flit_type, flit_vc, flit_dest, flit_src, flit_pkt_id, flit_seq}), 0);
    chk("t6_async_done", 32'(done), 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_no_tail_after_abort", 32'(flit_valid), 0);
    exp_flit(2'b01, 1, 5, 0, 0);
    exp_flit(2'b00, 1, 5, 0, 1);
    exp_flit(2'b00, 1, 5, 0, 2);
    exp_flit(2'b10, 1, 5, 0, 3);
    pulse_start(1);
    step();
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("t6_replay_%0d", s), 32'(flit_valid), 1);
    end
    step();
    chk("t6_done", 32'(done), 1);

    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
# packet_injector

Per-node traffic source that reads the packet list loaded into the NOC tables, as destination, VC and flit count per packet, and injects the resulting flits into the local router input port. Injection uses credit-based flow control with one credit counter per VC. The block sits between the per-CPU packet tables and the router's local input port, one instance per node. It starts on the global `start` pulse and flags `done` once every listed packet has left the node.

## Interface

- `NODE_ID`, 0: this node's index, driven on `flit_src`.
- `NUM_OF_ROUTERS`, 16: node count; dest/src width `NW = $clog2(NUM_OF_ROUTERS)`.
- `NUM_OF_VCS`, 2: VC count; VC width `VW = max(1,$clog2(NUM_OF_VCS))`.
- `VCS_SIZE`, 4: per-VC buffer depth at the router; also the credit reset value.
- `MAX_PACKETS`, 64: table depth; index width `PW = $clog2(MAX_PACKETS)`.
- `FLIT_CNT_W`, 8: width of the flit-count field.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level, sampled in IDLE.
- `num_of_packets` in PW+1: packet-list length for this node, sampled with `start`.
- `pkt_idx` out PW: table read address.
- `pkt_dest` in NW: table entry; must be valid in the same cycle as `pkt_idx`.
- `pkt_vc` in VW: table entry, same-cycle valid.
- `pkt_num_of_flits` in FLIT_CNT_W: table entry, same-cycle valid.
- `credit_valid` in 1: one credit returned this cycle.
- `credit_vc` in VW: VC of the returned credit.
- `flit_valid` out 1: flit present this cycle.
- `flit_type` out 2: 01 head, 00 body, 10 tail, 11 head+tail.
- `flit_vc` out VW: VC of the flit.
- `flit_dest` out NW: destination node.
- `flit_src` out NW: source node (`NODE_ID`).
- `flit_pkt_id` out PW: index of the packet the flit belongs to.
- `flit_seq` out FLIT_CNT_W: flit position within its packet, 0 = head.
- `done` out 1: all packets sent; sticky until reset.

## Operation

- **States.** The FSM has four states: IDLE, LOAD, SEND and DONE.
- **IDLE.**
  - On `start`=1: latch `num_of_packets` into `total` and clear `idx`.
  - If `total`=0, go to DONE; otherwise go to LOAD.
- **LOAD.**
  - `pkt_idx`=`idx`. Latch `pkt_dest`, `pkt_vc` and `pkt_num_of_flits` into `cur_*`, and clear `seq`.
  - If `pkt_num_of_flits`=0, the packet is skipped: increment `idx`, then go to DONE if `idx+1`=`total`, else stay in LOAD.
  - Otherwise go to SEND.
- **SEND.** Each cycle, if `credits[cur_vc]`>0, emit one flit:
  - `flit_type` = 11 if `cur_flits`=1; otherwise 01 when `seq`=0, 10 when `seq`=`cur_flits`−1, and 00 for all other flits.
  - After the last flit: increment `idx`, then go to DONE if `idx+1`=`total`, else go to LOAD.
  - If credits are zero, `flit_valid`=0 and the state holds (stall).
- **DONE.** `done`=1. The state is held until `rst`; `start` is ignored.
- **Credits.**
  - `credits[v]` is `$clog2(VCS_SIZE)+1` bits wide and resets to `VCS_SIZE`.
  - It decrements on a flit sent on VC v and increments on `credit_valid` with `credit_vc`=v.
  - If both happen on the same VC in the same cycle, the counter is unchanged.
  - A stall decision uses the registered counter; a credit arriving this cycle is usable from the next cycle.
  - A credit that would push a counter above `VCS_SIZE` is dropped, and a simulation `$display` error is issued.
  - Credits are tracked in every state, including IDLE and DONE.
- **Output registers.** All `flit_*` fields are registered. When `flit_valid`=0, the fields hold their last values.
- **VC order.** Packets are sent strictly in table order; there is no interleaving across VCs, so a stalled VC blocks the node.

## Timing

- **Reset values.** All outputs are 0: `flit_valid`, `flit_*`, `done` and `pkt_idx`. The FSM enters IDLE and all credits are set to `VCS_SIZE`.
- **Reset mid-operation.** Asserting `rst` during a packet aborts it immediately, with no tail emitted.
- **Latency.** `start` high at edge N → LOAD in cycle N+1 → first head flit valid after edge N+2, given a credit is available.
- **Throughput.** Packets are not back-to-back: there is one LOAD bubble cycle between packets.
- **Completion.** `done` rises on the edge after the final tail flit.

## Test plan

- **Single-flit packet.** `NODE_ID`=3, `num_of_packets`=1, entry {dest 5, vc 1, flits 1}, `start` pulse → exactly one flit with type 11, vc 1, dest 5, src 3, seq 0; `done`=1 on the next cycle.
- **Credit stall and resume.**
  - Stimulus: `VCS_SIZE`=4, one packet of 6 flits on vc 0, no credits returned.
  - Required: flits seq 0–3 (01,00,00,00), then `flit_valid`=0 holding.
  - Then one credit is returned on vc 0: seq 4 follows one cycle later. A second credit releases seq 5 (type 10), then `done`.
- **Simultaneous consume and return.** Credits at 1 on vc 0, with `credit_valid`=1 (vc 0) in every send cycle → a flit every cycle, and the counter stays at 1 throughout.
- **Multi-packet mixed VCs.**
  - Stimulus: entries {2,0,3}, {7,1,2}, {4,0,0}.
  - Required: 3 flits on vc 0, one bubble, 2 flits on vc 1; the zero-flit entry is skipped; `done` is asserted, and `flit_pkt_id` reads 0 then 1.
- **Empty list.** `num_of_packets`=0 with `start` → no flits; `done`=1 two edges after `start`.
- **Reset mid-packet.** `rst` asserted asynchronously mid-packet → all outputs 0 immediately and credits back at `VCS_SIZE`. A fresh `start` replays from packet 0.
